// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-first read bypass, hardwired x0
// and per-register busy bits for RAW hazard tracking.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ack,
    output logic                rsv_nack,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             ack_d;
    logic             nack_d;
    logic             wr_live;
    logic             rsv_zero;
    logic             eff_busy;

    assign wr_live  = wr_en && (wr_addr != '0);
    assign rsv_zero = (rsv_addr == '0);

    // Reservation sees the register already released by a same-cycle write.
    assign eff_busy = busy_q[rsv_addr] && !(wr_en && wr_addr == rsv_addr);

    always_comb begin
        busy_d = busy_q;
        ack_d  = 1'b0;
        nack_d = 1'b0;
        if (wr_live)
            busy_d[wr_addr] = 1'b0;
        if (rsv_en) begin
            unique case (1'b1)
                rsv_zero: ack_d = 1'b1;
                (!rsv_zero && eff_busy): nack_d = 1'b1;
                (!rsv_zero && !eff_busy): begin
                    busy_d[rsv_addr] = 1'b1;
                    ack_d = 1'b1;
                end
                default: ;
            endcase
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            rsv_ack  <= 1'b0;
            rsv_nack <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            rsv_ack  <= ack_d;
            rsv_nack <= nack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign busy_vec = busy_q;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] data_q;
        logic            busy_rq;
        logic            hit;

        assign a   = rd_addr[g*AW +: AW];
        assign hit = wr_en && (wr_addr == a);

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                busy_rq <= 1'b0;
            end else if (rd_en[g]) begin
                if (a == '0) begin
                    data_q  <= '0;
                    busy_rq <= 1'b0;
                end else if (hit) begin
                    data_q  <= wr_data;
                    busy_rq <= 1'b0;
                end else begin
                    data_q  <= regs[a];
                    busy_rq <= busy_q[a];
                end
            end
        end

        assign rd_data[g*XLEN +: XLEN] = data_q;
        assign rd_busy[g]              = busy_rq;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ack;
    logic                rsv_nack;
    logic [NREGS-1:0]    busy_vec;

    regfile_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ack(rsv_ack), .rsv_nack(rsv_nack),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [XLEN-1:0]     m_mem [NREGS];
    logic [NREGS-1:0]    m_busy;
    logic [NRD*XLEN-1:0] e_data;
    logic [NRD-1:0]      e_busy;
    logic                e_ack;
    logic                e_nack;

    task automatic idle();
        rst = 0; rd_en = '0; rd_addr = '0;
        wr_en = 0; wr_addr = '0; wr_data = '0;
        rsv_en = 0; rsv_addr = '0;
    endtask

    task automatic set_rd(input int p, input logic en, input int a);
        rd_en[p] = en;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    // Reference model: applies this cycle's inputs, then clocks the DUT.
    task automatic tick();
        if (rst) begin
            for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
            m_busy = '0; e_data = '0; e_busy = '0;
            e_ack = 0; e_nack = 0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                int a;
                a = int'(rd_addr[p*AW +: AW]);
                if (rd_en[p]) begin
                    if (a == 0) begin
                        e_data[p*XLEN +: XLEN] = '0; e_busy[p] = 0;
                    end else if (wr_en && int'(wr_addr) == a) begin
                        e_data[p*XLEN +: XLEN] = wr_data; e_busy[p] = 0;
                    end else begin
                        e_data[p*XLEN +: XLEN] = m_mem[a];
                        e_busy[p] = m_busy[a];
                    end
                end
            end
            e_ack = 0; e_nack = 0;
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr] = wr_data;
                m_busy[wr_addr] = 0;
            end
            if (rsv_en) begin
                if (rsv_addr == 0) e_ack = 1;
                else if (m_busy[rsv_addr]) e_nack = 1;
                else begin m_busy[rsv_addr] = 1; e_ack = 1; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; tick();
        rst = 1; wr_en = 1; wr_addr = 5; wr_data = 32'h1234;
        rsv_en = 1; rsv_addr = 6; set_rd(0, 1, 5);
        tick();
        idle();
        n_vec++;
        if (busy_vec !== '0 || rsv_ack !== 0 || rsv_nack !== 0) begin
            n_err++;
            $display("FAIL reset_flags: got busy=%h ack=%b nack=%b want 0",
                     busy_vec, rsv_ack, rsv_nack);
        end
        n_vec++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            n_err++;
            $display("FAIL reset_rd: got %h/%b want 0", rd_data, rd_busy);
        end
        set_rd(0, 1, 5); tick(); idle();
        n_vec++;
        if (rd_data[31:0] !== 32'h0) begin
            n_err++;
            $display("FAIL reset_r5: got %h want 0", rd_data[31:0]);
        end
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1; wr_addr = 3; wr_data = 32'hDEADBEEF; tick();
        idle(); set_rd(0, 1, 3); set_rd(1, 1, 0); tick(); idle();
        n_vec++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL read_r3: got %h want deadbeef", rd_data[31:0]);
        end
        n_vec++;
        if (rd_data[63:32] !== 32'h0) begin
            n_err++;
            $display("FAIL read_r0: got %h want 0", rd_data[63:32]);
        end
        tick();
        n_vec++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL hold_p0: got %h want deadbeef", rd_data[31:0]);
        end
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
        set_rd(0, 1, 7); set_rd(1, 1, 7); tick(); idle();
        n_vec++;
        if (rd_data !== {2{32'hA5A5A5A5}} || rd_busy !== 2'b00) begin
            n_err++;
            $display("FAIL bypass_r7: got %h/%b want a5a5a5a5 x2/00",
                     rd_data, rd_busy);
        end
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
        set_rd(1, 1, 0); tick(); idle();
        n_vec++;
        if (rd_data[63:32] !== 32'h0) begin
            n_err++;
            $display("FAIL bypass_x0: got %h want 0", rd_data[63:32]);
        end
        set_rd(0, 1, 0); tick(); idle();
        n_vec++;
        if (rd_data[31:0] !== 32'h0) begin
            n_err++;
            $display("FAIL write_x0: got %h want 0", rd_data[31:0]);
        end
    endtask

    task automatic test_reserve();
        idle();
        rsv_en = 1; rsv_addr = 4; tick(); idle();
        n_vec++;
        if (rsv_ack !== 1 || rsv_nack !== 0 || busy_vec[4] !== 1) begin
            n_err++;
            $display("FAIL rsv_r4: got ack=%b nack=%b busy=%b want 1/0/1",
                     rsv_ack, rsv_nack, busy_vec[4]);
        end
        rsv_en = 1; rsv_addr = 4; tick(); idle();
        n_vec++;
        if (rsv_ack !== 0 || rsv_nack !== 1) begin
            n_err++;
            $display("FAIL rsv_again: got ack=%b nack=%b want 0/1",
                     rsv_ack, rsv_nack);
        end
        set_rd(0, 1, 4); tick(); idle();
        n_vec++;
        if (rd_busy[0] !== 1 || rsv_ack !== 0 || rsv_nack !== 0) begin
            n_err++;
            $display("FAIL rd_busy_r4: got busy=%b ack=%b nack=%b want 1/0/0",
                     rd_busy[0], rsv_ack, rsv_nack);
        end
        wr_en = 1; wr_addr = 4; wr_data = 32'h55; tick(); idle();
        n_vec++;
        if (busy_vec[4] !== 0) begin
            n_err++;
            $display("FAIL release_r4: got %b want 0", busy_vec[4]);
        end
    endtask

    task automatic test_write_reserve();
        idle();
        rsv_en = 1; rsv_addr = 9; tick(); idle();
        wr_en = 1; wr_addr = 9; wr_data = 32'h77;
        rsv_en = 1; rsv_addr = 9; tick(); idle();
        n_vec++;
        if (rsv_ack !== 1 || rsv_nack !== 0 || busy_vec[9] !== 1) begin
            n_err++;
            $display("FAIL wr_rsv_r9: got ack=%b nack=%b busy=%b want 1/0/1",
                     rsv_ack, rsv_nack, busy_vec[9]);
        end
        set_rd(1, 1, 9); tick(); idle();
        n_vec++;
        if (rd_data[63:32] !== 32'h77 || rd_busy[1] !== 1) begin
            n_err++;
            $display("FAIL r9_data: got %h/%b want 77/1",
                     rd_data[63:32], rd_busy[1]);
        end
    endtask

    task automatic test_x0_reserve();
        idle();
        rst = 1; tick(); idle();
        rsv_en = 1; rsv_addr = 0; tick(); idle();
        n_vec++;
        if (rsv_ack !== 1 || busy_vec !== '0) begin
            n_err++;
            $display("FAIL rsv_x0: got ack=%b busy=%h want 1/0",
                     rsv_ack, busy_vec);
        end
        rsv_en = 1; rsv_addr = 2; set_rd(0, 1, 2); tick(); idle();
        n_vec++;
        if (rd_busy[0] !== 0 || rsv_ack !== 1) begin
            n_err++;
            $display("FAIL rsv_rd_same: got busy=%b ack=%b want 0/1",
                     rd_busy[0], rsv_ack);
        end
        set_rd(0, 1, 2); tick(); idle();
        n_vec++;
        if (rd_busy[0] !== 1) begin
            n_err++;
            $display("FAIL rsv_rd_next: got %b want 1", rd_busy[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 60) == 0);
            rd_en    = NRD'($urandom);
            rd_addr  = (NRD*AW)'($urandom);
            wr_en    = $urandom_range(0, 1) == 1;
            wr_addr  = AW'($urandom_range(0, 7));
            wr_data  = $urandom;
            rsv_en   = $urandom_range(0, 2) != 0;
            rsv_addr = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr;
            if ($urandom_range(0, 3) == 0) rd_addr[AW +: AW] = rd_addr[AW-1:0];
            tick();
            n_vec++;
            if (rd_data !== e_data || rd_busy !== e_busy) begin
                n_err++;
                $display("FAIL rand_rd c=%0d: got %h/%b want %h/%b",
                         c, rd_data, rd_busy, e_data, e_busy);
            end
            n_vec++;
            if (busy_vec !== m_busy || rsv_ack !== e_ack || rsv_nack !== e_nack) begin
                n_err++;
                $display("FAIL rand_rsv c=%0d: got %h %b%b want %h %b%b",
                         c, busy_vec, rsv_ack, rsv_nack, m_busy, e_ack, e_nack);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_reserve();
        test_write_reserve();
        test_x0_reserve();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's 2-read/1-write register file for the multicycle RISC-V control/datapath.
- Adds N registered read ports with write-first bypass, a hardwired-zero x0 and per-register busy bits.
- The control FSM reserves a destination register at decode and detects RAW hazards when reading operands; writeback releases the register.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two and at least 2.
- NRD, 2, number of read ports; must be at least 1.
- AW, $clog2(NREGS), address width. Localparam; must not be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- rd_en  in  NRD  per-port read strobe
- rd_addr  in  NRD*AW  port i address is bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  registered read data; port i is bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  registered busy flag of the register read on port i
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- rsv_en  in  1  request to mark rsv_addr busy
- rsv_addr  in  AW  register to reserve
- rsv_ack  out  1  registered; reservation accepted
- rsv_nack  out  1  registered; reservation refused because the register is still busy
- busy_vec  out  NREGS  registered busy bits; bit 0 is always 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all registers, rd_data, rd_busy, busy_vec, rsv_ack and rsv_nack are 0. rst dominates every other input in the same cycle, including a read, write or reservation in progress.
- Read latency is 1 cycle.
  - At the posedge where rd_en[i]=1, rd_data[i] and rd_busy[i] update.
  - While rd_en[i]=0, rd_data[i] and rd_busy[i] hold their values.
- x0 reads: return 0 and rd_busy=0.
- Read bypass (write-first): if wr_en=1, wr_addr==rd_addr[i] and wr_addr!=0 in the same cycle, then:
  - rd_data[i] = wr_data;
  - rd_busy[i] = 0, because the write releases the register.
- Otherwise a read returns the stored value, and rd_busy[i] = busy[rd_addr[i]] as it was before the edge.
- A reservation made in the same cycle is NOT visible to a same-cycle read.
- Multiple ports may read the same address in one cycle; each gets an identical result.
- Write:
  - wr_en=1 with wr_addr!=0 stores wr_data at the edge and clears busy[wr_addr].
  - Writes to x0 are discarded.
  - Writing a non-busy register is legal; busy stays 0.
- Reservation is evaluated against the busy state after a same-cycle write:
  - eff_busy = busy[rsv_addr] & ~(wr_en & wr_addr==rsv_addr).
  - If eff_busy=0: set busy[rsv_addr]; rsv_ack=1 and rsv_nack=0 on the next cycle.
  - If eff_busy=1: busy is unchanged; rsv_nack=1 and rsv_ack=0 on the next cycle.
  - The requester must retry; the block queues nothing.
  - rsv_addr=0 is always acked and never sets busy.
  - When rsv_en=0, rsv_ack and rsv_nack are 0 on the next cycle (single-cycle pulses).
- Simultaneous write and reserve to the same register R: the write stores and releases R, the reserve re-acquires it. Result: busy[R]=1 and rsv_ack=1.
- busy_vec mirrors the busy bits after every edge.
- Out-of-range addresses cannot occur, since NREGS is a power of two.

Test Plan:
- Reset, then pulse rst while wr_en=1 with wr_addr=5, wr_data=32'h1234 -> the register is not written; reading r5 next returns 0; busy_vec=0, rsv_ack=0, rsv_nack=0.
- Write r3=32'hDEADBEEF. Next cycle read port0=r3 and port1=r0 -> one cycle later rd_data port0=32'hDEADBEEF, port1=0.
- Same-cycle write r7=32'hA5A5A5A5 and read r7 on both ports -> both ports return 32'hA5A5A5A5 with rd_busy=0. Then write r0=32'hFFFFFFFF -> a read of r0 returns 0.
- Reserve r4 -> rsv_ack=1 and busy_vec[4]=1. Reserve r4 again -> rsv_nack=1. Read r4 -> rd_busy=1. Write r4=32'h55 -> busy_vec[4]=0.
- With r9 busy, issue wr_en r9=32'h77 and rsv_en r9 in the same cycle -> rsv_ack=1, busy_vec[9]=1, r9=32'h77.
- Reserve r0 -> rsv_ack=1 and busy_vec stays 0. Reserve r2 and read r2 in the same cycle -> rd_busy=0 for that read; a read the next cycle -> rd_busy=1.
